// File: rtl/shift_arbiter.sv
// ---------------------------------------------------------------------------
// shift_arbiter
//
// Shares one combinational 32-bit barrel shifter between two requesters.
// Requests use valid/ready. Arbitration is round-robin, or fixed-priority
// (requester 0 wins) when FIXED_PRIO=1. An accepted request's operands are
// registered. The shifter result is presented the next cycle and held until
// the consumer accepts it. Back-to-back throughput is one result per cycle.
//
// Parameters:
//   FIXED_PRIO  1: requester 0 always wins a conflict, 0: round-robin
//   RESET_LAST  last-grant pointer value after reset
//
// Ports:
//   clk, rst_n                       clock (rising edge), async active-low reset
//   reqX_valid / reqX_ready          request handshake, X = 0, 1
//   reqX_a [31:0]                    operand
//   reqX_n [4:0]                     shift amount
//   reqX_funct [1:0]                 0 SLL, 2 SRL, 3 SRA, 1 reserved (result 0)
//   rsp_valid / rsp_ready            response handshake
//   rsp_data [31:0]                  shift result
//   rsp_id                           requester that owns rsp_data
//   busy                             high while a result is held
// ---------------------------------------------------------------------------
module shift_arbiter #(
   parameter bit FIXED_PRIO = 1'b0,
   parameter bit RESET_LAST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [4:0]  req0_n,
   input  logic [1:0]  req0_funct,

   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [4:0]  req1_n,
   input  logic [1:0]  req1_funct,

   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        rsp_id,
   output logic        busy
);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_e;

   localparam logic [1:0] FUNCT_SLL = 2'd0;
   localparam logic [1:0] FUNCT_SRL = 2'd2;
   localparam logic [1:0] FUNCT_SRA = 2'd3;

   state_e      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [4:0]  n_q, n_d;
   logic [1:0]  funct_q, funct_d;
   logic        id_q, id_d;
   logic        last_q, last_d;

   logic        can_accept;
   logic        grant;
   logic        accept;

   // ------------------------------------------------------------------------
   // Arbitration and readiness
   // ------------------------------------------------------------------------
   // A held result can be replaced in the same cycle it is consumed, which is
   // what gives one result per cycle under back-to-back traffic.
   assign can_accept = (state_q == IDLE) || ((state_q == HOLD) && rsp_ready);

   always_comb begin
      // NOTE: every always_comb output gets a default first so that no path
      // leaves it unassigned and infers a latch.
      grant = 1'b0;
      if (req0_valid && req1_valid) begin
         // Round-robin: the requester that did not win last time.
         grant = FIXED_PRIO ? 1'b0 : ~last_q;
      end else if (req1_valid) begin
         grant = 1'b1;
      end
   end

   // Gated by rst_n so that neither requester sees ready while in reset.
   assign req0_ready = rst_n && can_accept && req0_valid && (grant == 1'b0);
   assign req1_ready = rst_n && can_accept && req1_valid && (grant == 1'b1);
   assign accept     = req0_ready || req1_ready;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         n_q     <= '0;
         funct_q <= FUNCT_SLL;
         id_q    <= 1'b0;
         last_q  <= RESET_LAST;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples its next value from the same pre-edge snapshot.
         state_q <= state_d;
         a_q     <= a_d;
         n_q     <= n_d;
         funct_q <= funct_d;
         id_q    <= id_d;
         last_q  <= last_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      n_d     = n_q;
      funct_d = funct_q;
      id_d    = id_q;
      last_d  = last_q;

      if (accept) begin
         state_d = HOLD;
         id_d    = grant;
         last_d  = grant;
         if (grant) begin
            a_d     = req1_a;
            n_d     = req1_n;
            funct_d = req1_funct;
         end else begin
            a_d     = req0_a;
            n_d     = req0_n;
            funct_d = req0_funct;
         end
      end else if ((state_q == HOLD) && rsp_ready) begin
         state_d = IDLE;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   always_comb begin
      rsp_valid = (state_q == HOLD);
      busy      = (state_q == HOLD);
      rsp_id    = id_q;
   end

   // Shifter operates on the registered operands, so rsp_data is stable for
   // as long as the operands are held.
   always_comb begin
      rsp_data = '0;
      unique case (funct_q)
         FUNCT_SLL: rsp_data = a_q << n_q;
         FUNCT_SRL: rsp_data = a_q >> n_q;
         FUNCT_SRA: rsp_data = $unsigned($signed(a_q) >>> n_q);
         default:   rsp_data = '0;
      endcase
   end

endmodule

// File: tb/tb_shift_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shift_arbiter
//
// Directed bench for shift_arbiter. Two instances share all inputs: dut is
// round-robin, dut_fp is fixed-priority. Inputs change on the falling edge;
// combinational readiness is sampled 1 ns later and registered outputs 1 ns
// after the rising edge.
// ---------------------------------------------------------------------------
module tb_shift_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic [31:0] req0_a, req1_a;
   logic [4:0]  req0_n, req1_n;
   logic [1:0]  req0_funct, req1_funct;
   logic        rsp_ready;

   logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
   logic [31:0] rsp_data;
   logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_busy;
   logic [31:0] fp_rsp_data;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_arbiter #(.FIXED_PRIO(1'b0), .RESET_LAST(1'b1)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_n     (req0_n),
      .req0_funct (req0_funct),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_n     (req1_n),
      .req1_funct (req1_funct),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_id     (rsp_id),
      .busy       (busy)
   );

   shift_arbiter #(.FIXED_PRIO(1'b1), .RESET_LAST(1'b1)) dut_fp (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_ready (fp_req0_ready),
      .req0_a     (req0_a),
      .req0_n     (req0_n),
      .req0_funct (req0_funct),
      .req1_valid (req1_valid),
      .req1_ready (fp_req1_ready),
      .req1_a     (req1_a),
      .req1_n     (req1_n),
      .req1_funct (req1_funct),
      .rsp_valid  (fp_rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (fp_rsp_data),
      .rsp_id     (fp_rsp_id),
      .busy       (fp_busy)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_req0(input logic v, input logic [31:0] a,
                           input logic [4:0] n, input logic [1:0] f);
      req0_valid = v; req0_a = a; req0_n = n; req0_funct = f;
   endtask

   task automatic set_req1(input logic v, input logic [31:0] a,
                           input logic [4:0] n, input logic [1:0] f);
      req1_valid = v; req1_a = a; req1_n = n; req1_funct = f;
   endtask

   // Rising edge, then settle.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Falling edge (input change point).
   task automatic fall();
      @(negedge clk);
   endtask

   // One transaction from a single requester with the consumer ready;
   // checks readiness in the accept cycle and the result the cycle after.
   task automatic single(input string tag, input logic id, input logic [31:0] a,
                         input logic [4:0] n, input logic [1:0] f,
                         input logic [31:0] exp);
      fall();
      set_req0(1'b0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0);
      if (id) set_req1(1'b1, a, n, f);
      else    set_req0(1'b1, a, n, f);
      rsp_ready = 1'b1;
      #1;
      check({tag, " ready"}, id ? req1_ready : req0_ready, 1'b1);
      tick();
      check({tag, " valid"}, rsp_valid, 1'b1);
      check({tag, " data"}, rsp_data, exp);
      check({tag, " id"}, rsp_id, id);
   endtask

   initial begin
      // ---------------- reset state ----------------
      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      set_req0(1'b1, 32'h1, 5'd1, 2'd0);
      set_req1(1'b1, 32'h1, 5'd1, 2'd0);
      #2;
      check("rst rsp_valid", rsp_valid, 1'b0);
      check("rst rsp_data", rsp_data, 32'h0);
      check("rst rsp_id", rsp_id, 1'b0);
      check("rst busy", busy, 1'b0);
      check("rst req0_ready", req0_ready, 1'b0);
      check("rst req1_ready", req1_ready, 1'b0);

      // ---------------- contention, both valid for 4 cycles ----------------
      // req0: 1 << 1 = 2, req1: 0x100 >> 4 = 0x10
      fall();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      set_req0(1'b1, 32'h0000_0001, 5'd1, 2'd0);
      set_req1(1'b1, 32'h0000_0100, 5'd4, 2'd2);
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("rr%0d req0_ready", i), req0_ready, (i % 2) == 0);
         check($sformatf("rr%0d req1_ready", i), req1_ready, (i % 2) == 1);
         check($sformatf("fp%0d req0_ready", i), fp_req0_ready, 1'b1);
         check($sformatf("fp%0d req1_ready", i), fp_req1_ready, 1'b0);
         tick();
         check($sformatf("rr%0d valid", i), rsp_valid, 1'b1);
         check($sformatf("rr%0d id", i), rsp_id, (i % 2) == 1);
         check($sformatf("rr%0d data", i), rsp_data,
               (i % 2) ? 32'h0000_0010 : 32'h0000_0002);
         check($sformatf("fp%0d id", i), fp_rsp_id, 1'b0);
         check($sformatf("fp%0d data", i), fp_rsp_data, 32'h0000_0002);
         fall();
      end

      // drain: no requests, consumer ready -> back to IDLE
      set_req0(1'b0, '0, '0, '0);
      set_req1(1'b0, '0, '0, '0);
      tick();
      check("drain valid", rsp_valid, 1'b0);
      check("drain busy", busy, 1'b0);

      // ---------------- single requests / shifter cases ----------------
      single("sll", 1'b0, 32'h0000_00F0, 5'd4,  2'd0, 32'h0000_0F00);
      single("sra31", 1'b1, 32'h8000_0000, 5'd31, 2'd3, 32'hFFFF_FFFF);
      single("sra0", 1'b1, 32'h8000_0000, 5'd0,  2'd3, 32'h8000_0000);
      single("rsvd", 1'b1, 32'h8000_0000, 5'd31, 2'd1, 32'h0000_0000);
      single("srl", 1'b0, 32'hF000_0000, 5'd8,  2'd2, 32'h00F0_0000);
      single("sra_pos", 1'b1, 32'h4000_0000, 5'd4, 2'd3, 32'h0400_0000);

      // ---------------- backpressure ----------------
      // held result 3 << 2 = 0xC, waiting req1 0xFF << 4 = 0xFF0
      single("bp first", 1'b0, 32'h0000_0003, 5'd2, 2'd0, 32'h0000_000C);
      fall();
      rsp_ready = 1'b0;
      set_req0(1'b0, '0, '0, '0);
      set_req1(1'b1, 32'h0000_00FF, 5'd4, 2'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check($sformatf("bp%0d req1_ready", i), req1_ready, 1'b0);
         tick();
         check($sformatf("bp%0d valid", i), rsp_valid, 1'b1);
         check($sformatf("bp%0d data", i), rsp_data, 32'h0000_000C);
         check($sformatf("bp%0d id", i), rsp_id, 1'b0);
         fall();
      end
      rsp_ready = 1'b1;
      #1;
      check("bp release req1_ready", req1_ready, 1'b1);
      tick();
      check("bp next valid", rsp_valid, 1'b1);
      check("bp next data", rsp_data, 32'h0000_0FF0);
      check("bp next id", rsp_id, 1'b1);

      // ---------------- async reset while holding ----------------
      fall();
      rsp_ready = 1'b0;
      set_req1(1'b0, '0, '0, '0);
      #2;
      check("pre-rst busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("async rst valid", rsp_valid, 1'b0);
      check("async rst busy", busy, 1'b0);
      check("async rst data", rsp_data, 32'h0);
      fall();
      rst_n = 1'b1;
      tick();
      check("post-rst no rsp", rsp_valid, 1'b0);
      fall();
      set_req0(1'b1, 32'h0000_0005, 5'd1, 2'd0);
      set_req1(1'b1, 32'h0000_0005, 5'd2, 2'd0);
      #1;
      check("post-rst req0_ready", req0_ready, 1'b1);
      check("post-rst req1_ready", req1_ready, 1'b0);
      tick();
      check("post-rst id", rsp_id, 1'b0);
      check("post-rst data", rsp_data, 32'h0000_000A);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
Shares one combinational 32-bit barrel shifter (SLL/SRL/SRA, funct 0/2/3) between two requesters, e.g. the ALU issue path and the address/immediate unit. Each request port and the single response port use a valid/ready handshake. Requests are arbitrated round-robin, or fixed-priority when configured. Operands are captured in registers, and the result is presented one cycle later and held until accepted.

Parameters:
FIXED_PRIO, 0, 1 = requester 0 always wins a conflict; 0 = round-robin
RESET_LAST, 1, value of the last-grant pointer after reset (1 means requester 0 wins the first conflict)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a request
req0_ready  out  1  requester 0 request accepted this cycle
req0_a  in  32  requester 0 operand
req0_n  in  5  requester 0 shift amount
req0_funct  in  2  requester 0 op: 0 SLL, 2 SRL, 3 SRA, 1 reserved
req1_valid / req1_ready / req1_a / req1_n / req1_funct  same widths and meanings, requester 1
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_data  out  32  shift result
rsp_id  out  1  requester that owns rsp_data
busy  out  1  high when state is HOLD

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rsp_valid=0, rsp_data=0, rsp_id=0, busy=0.
  - Operand registers = 0; last-grant pointer = RESET_LAST.
  - req*_ready reads 0 while rst_n=0.
- States:
  - IDLE: no result pending.
  - HOLD: rsp_valid=1; result pending until accepted.
- can_accept = (state==IDLE) | (state==HOLD & rsp_ready).
- Grant selection (combinational):
  - Only one valid request: that requester.
  - Both valid, FIXED_PRIO=1: requester 0.
  - Both valid, FIXED_PRIO=0: the requester not equal to the last-grant pointer.
- Readiness:
  - reqX_ready = can_accept & reqX_valid & (grant==X).
  - At most one ready per cycle.
  - reqX_ready may depend combinationally on rsp_ready.
- On acceptance edge:
  - Capture a, n, funct into operand registers; rsp_id <= grant.
  - Last-grant pointer <= grant (only on acceptance); state <= HOLD.
- Output path:
  - rsp_data is driven by the shifter on the registered operands.
  - Latency: request accepted in cycle T, rsp_valid=1 in cycle T+1.
- In HOLD:
  - rsp_data, rsp_id and the operands stay stable until rsp_ready=1.
  - rsp_ready=1 with no acceptable request: state <= IDLE, rsp_valid <= 0.
  - rsp_ready=1 with a valid request: new request accepted the same cycle, state stays HOLD. Back-to-back throughput is 1 result per cycle.
- Shifter semantics:
  - SLL/SRL are zero-fill.
  - SRA replicates a[31]; n=0 returns a unchanged (including negative a).
  - Reserved funct=1 produces rsp_data=0 and is still a normal transaction, handshake included.
- Request rules:
  - A requester holds valid and its fields stable until ready.
  - Dropping valid before ready is tolerated: nothing is captured.
  - Operand changes while not ready are ignored.
- rsp_ready while rsp_valid=0: ignored.
- Reset mid-HOLD: the result is discarded, outputs go to reset values immediately, and no response is produced after reset release.

Test Plan:
- Single request: req0 a=0x0000_00F0, n=4, funct=0 -> req0_ready=1 in T. At T+1: rsp_valid=1, rsp_data=0x0000_0F00, rsp_id=0.
- SRA sign fill: req1 a=0x8000_0000, n=31, funct=3 -> rsp_data=0xFFFF_FFFF, rsp_id=1. Repeat with n=0 -> 0x8000_0000. Repeat with funct=1 -> 0.
- Round-robin contention, FIXED_PRIO=0, rsp_ready=1, both valid for 4 cycles -> grants 0,1,0,1 and rsp_id sequence 0,1,0,1 with one result per cycle. With FIXED_PRIO=1 -> grants 0,0,0,0, and req1 is never ready.
- Backpressure: rsp_ready=0 for 3 cycles after a result, with req1 valid -> rsp_data/rsp_id stable and req1_ready=0. When rsp_ready rises: req1_ready=1 in the same cycle, and the next result follows on the next cycle.
- SRL zero-fill: a=0xF000_0000, n=8, funct=2 -> 0x00F0_0000.
- Async reset in HOLD: assert rst_n=0 mid-cycle -> rsp_valid=0 and busy=0 without a clock edge. After release with both valid -> requester 0 is granted first (RESET_LAST=1).
